activation_relu_stream: RTL and testbench

Streaming, clocked successor to the combinational full-frame ReLU stage of the FP16 LeNet datapath. Accepts a feature map as LANES FP16 values per beat over a valid/ready handshake. Applies one of four run-time activation modes and tracks pixel/channel position so downstream pooling can see frame and channel boundaries. Sits between a convolution output stream (C1/C3) and the pooling stage.

---
 rtl/activation_relu_stream_if.sv | 33 +++
 rtl/activation_relu_stream.sv | 129 ++++++++++++
 tb/tb_activation_relu_stream.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/activation_relu_stream_if.sv
// Stream bundle for the FP16 activation stage: input beats, activated output
// beats with channel/frame tags, the run-time mode and the frame_done pulse.
interface activation_relu_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int CHANNELS   = 6
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // A beat moves on a rising edge where valid && ready. The producer holds
  // valid and data stable until that edge; ready may never depend on valid.
  logic [1:0]                  mode;
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*DATA_WIDTH-1:0] out_data;
  logic [CHAN_W-1:0]           out_chan;
  logic                        out_last_chan;
  logic                        out_last;
  logic                        frame_done;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan, out_last_chan, out_last, frame_done
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan, out_last_chan, out_last, frame_done
  );
endinterface

// File: rtl/activation_relu_stream.sv
// Streaming FP16 activation (bypass / ReLU / leaky ReLU / ReLU6) with a single
// output register stage and per-beat channel/frame position tags.
module activation_relu_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int H          = 28,
  parameter int W          = 28,
  parameter int CHANNELS   = 6,
  parameter int LEAK_SHIFT = 3
) (
  input  logic clk,
  input  logic rst_n,
  activation_relu_stream_if.slave bus
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BEATS  = (H * W) / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BUS_W  = LANES * DATA_WIDTH;
  localparam logic [4:0] LS = 5'(LEAK_SHIFT);

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_RELU   = 2'b01;
  localparam logic [1:0] MODE_LEAKY  = 2'b10;
  localparam logic [1:0] MODE_RELU6  = 2'b11;

  logic [BEAT_W-1:0] beat_q;
  logic [CHAN_W-1:0] chan_q;
  logic [1:0]        mode_q;
  logic              out_valid_q;
  logic [BUS_W-1:0]  out_data_q;
  logic [CHAN_W-1:0] out_chan_q;
  logic              out_last_chan_q;
  logic              out_last_q;
  logic              frame_done_q;

  logic              accept;
  logic              frame_start;
  logic              last_beat;
  logic              last_chan;
  logic [1:0]        eff_mode;
  logic [BUS_W-1:0]  act_data;

  function automatic logic [15:0] act_lane(input logic [15:0] x, input logic [1:0] md);
    logic       s;
    logic [4:0] e;
    logic [9:0] m;
    logic       nan;
    s   = x[15];
    e   = x[14:10];
    m   = x[9:0];
    nan = (e == 5'h1f) && (m != 10'h000);
    act_lane = x;
    if (md != MODE_BYPASS && nan) begin
      act_lane = 16'h7E00;
    end else begin
      case (md)
        MODE_RELU:  if (s) act_lane = 16'h0000;
        MODE_LEAKY: begin
          // Scaling by 2^-LEAK_SHIFT is an exponent decrement; values that
          // would underflow the normal range flush to -0.
          if (s) begin
            if (e == 5'h1f)  act_lane = 16'hFC00;
            else if (e > LS) act_lane = {1'b1, e - LS, m};
            else             act_lane = 16'h8000;
          end
        end
        MODE_RELU6: begin
          if (s)                         act_lane = 16'h0000;
          else if (x[14:0] > 15'h4600)   act_lane = 16'h4600;
        end
        default: ;
      endcase
    end
  endfunction

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign frame_start  = (beat_q == '0) && (chan_q == '0);
  assign last_beat    = (beat_q == BEAT_W'(BEATS - 1));
  assign last_chan    = (chan_q == CHAN_W'(CHANNELS - 1));
  // The first beat of a frame already uses the mode it latches.
  assign eff_mode     = frame_start ? bus.mode : mode_q;

  always_comb begin
    act_data = '0;
    for (int k = 0; k < LANES; k++) begin
      act_data[k*DATA_WIDTH +: DATA_WIDTH] = act_lane(bus.in_data[k*DATA_WIDTH +: DATA_WIDTH], eff_mode);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_chan_q      <= '0;
      out_last_chan_q <= 1'b0;
      out_last_q      <= 1'b0;
      frame_done_q    <= 1'b0;
      beat_q          <= '0;
      chan_q          <= '0;
      mode_q          <= MODE_RELU;
    end else begin
      frame_done_q <= out_valid_q && bus.out_ready && out_last_q;
      if (accept) begin
        out_valid_q     <= 1'b1;
        out_data_q      <= act_data;
        out_chan_q      <= chan_q;
        out_last_chan_q <= last_beat;
        out_last_q      <= last_beat && last_chan;
        if (frame_start) mode_q <= bus.mode;
        if (last_beat) begin
          beat_q <= '0;
          chan_q <= last_chan ? '0 : chan_q + 1'b1;
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_chan      = out_chan_q;
  assign bus.out_last_chan = out_last_chan_q;
  assign bus.out_last      = out_last_q;
  assign bus.frame_done    = frame_done_q;
endmodule

// File: tb/tb_activation_relu_stream.sv
// Bench for activation_relu_stream: directed lane patterns, full frames with
// random backpressure, mid-frame mode change, and reset while stalled.
module tb_activation_relu_stream;
  localparam int DW         = 16;
  localparam int LANES      = 4;
  localparam int H          = 28;
  localparam int W          = 28;
  localparam int CHANNELS   = 6;
  localparam int LEAK_SHIFT = 3;
  localparam int BEATS      = H * W / LANES;
  localparam int FRAME      = BEATS * CHANNELS;
  localparam int CHAN_W     = 3;
  localparam int BUS_W      = DW * LANES;
  localparam int EW         = CHAN_W + 2 + BUS_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  activation_relu_stream_if #(.DATA_WIDTH(DW), .LANES(LANES), .CHANNELS(CHANNELS)) bus ();

  activation_relu_stream #(
    .DATA_WIDTH(DW), .LANES(LANES), .H(H), .W(W),
    .CHANNELS(CHANNELS), .LEAK_SHIFT(LEAK_SHIFT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int compares = 0;
  int fails    = 0;
  logic [EW-1:0] exp_q[$];
  logic fd_exp     = 1'b0;
  int   fd_count   = 0;
  logic rand_ready = 1'b0;
  logic ready_force = 1'b1;
  int   tb_beat = 0;
  int   tb_chan = 0;
  logic [1:0] tb_mode_q = 2'b01;
  logic [EW-1:0] mon_e;
  logic mon_last;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_act(input logic [15:0] x, input logic [1:0] md);
    logic [4:0] ex;
    ex = x[14:10];
    if (md == 2'd0) return x;
    if (ex == 5'd31 && x[9:0] != 10'd0) return 16'h7E00;
    if (md == 2'd1) return x[15] ? 16'h0000 : x;
    if (md == 2'd3) return x[15] ? 16'h0000 : ((x[14:0] > 15'h4600) ? 16'h4600 : x);
    if (!x[15]) return x;
    if (ex == 5'd31) return 16'hFC00;
    if (int'(ex) > LEAK_SHIFT) return {1'b1, 5'(int'(ex) - LEAK_SHIFT), x[9:0]};
    return 16'h8000;
  endfunction

  function automatic logic [15:0] rand_lane();
    logic [15:0] specials[8];
    specials = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E01, 16'h4600, 16'h4601, 16'h8001};
    if ($urandom_range(0, 5) == 0) return specials[$urandom_range(0, 7)];
    return 16'($urandom());
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
    tb_beat = 0;
    tb_chan = 0;
  endtask

  task automatic send_beat(input logic [BUS_W-1:0] d);
    logic ok;
    logic [BUS_W-1:0] ed;
    logic lc, lf;
    int n;
    ok = 1'b0;
    n  = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!ok && n < 400) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        if (tb_beat == 0 && tb_chan == 0) tb_mode_q = bus.mode;
        for (int k = 0; k < LANES; k++) ed[k*DW +: DW] = ref_act(d[k*DW +: DW], tb_mode_q);
        lc = (tb_beat == BEATS - 1);
        lf = lc && (tb_chan == CHANNELS - 1);
        exp_q.push_back({CHAN_W'(tb_chan), lc, lf, ed});
        if (lc) begin
          tb_beat = 0;
          tb_chan = (tb_chan == CHANNELS - 1) ? 0 : tb_chan + 1;
        end else begin
          tb_beat++;
        end
      end
      step();
      n++;
    end
    bus.in_valid = 1'b0;
    chk("in_accept_timeout", 80'(ok), 80'(1'b1));
  endtask

  task automatic send_frame(input int n, input int sw_at, input logic [1:0] sw_mode);
    for (int i = 0; i < n; i++) begin
      if (i == sw_at) bus.mode = sw_mode;
      if ($urandom_range(0, 3) == 0) step();
      send_beat({rand_lane(), rand_lane(), rand_lane(), rand_lane()});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      step();
      n++;
    end
    chk("drain_left", 80'(exp_q.size()), 80'(0));
    repeat (3) step();
  endtask

  task automatic direct(input string tag, input logic [1:0] md,
                        input logic [BUS_W-1:0] d, input logic [BUS_W-1:0] want);
    bus.mode = md;
    send_beat(d);
    @(negedge clk);
    chk({tag, "_latency_valid"}, 80'(bus.out_valid), 80'(1'b1));
    chk({tag, "_data"}, 80'(bus.out_data), 80'(want));
    step();
    step();
    do_reset(1);
  endtask

  // out_ready updates 2 time units after each edge, so the driver's #1 choices land the same cycle
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      fd_exp = 1'b0;
    end else begin
      chk("frame_done", 80'(bus.frame_done), 80'(fd_exp));
      if (bus.frame_done) fd_count++;
      mon_last = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        chk("beat_expected", 80'(exp_q.size() != 0), 80'(1'b1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("out_beat", 80'({bus.out_chan, bus.out_last_chan, bus.out_last, bus.out_data}), 80'(mon_e));
          mon_last = mon_e[BUS_W];
        end
      end
      fd_exp = mon_last;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.mode     = 2'b01;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    do_reset(3);

    @(negedge clk);
    chk("rst_out_valid",     80'(bus.out_valid),     80'(1'b0));
    chk("rst_out_data",      80'(bus.out_data),      80'(0));
    chk("rst_out_chan",      80'(bus.out_chan),      80'(0));
    chk("rst_out_last_chan", 80'(bus.out_last_chan), 80'(1'b0));
    chk("rst_out_last",      80'(bus.out_last),      80'(1'b0));
    chk("rst_in_ready",      80'(bus.in_ready),      80'(1'b1));
    step();

    direct("relu",   2'b01, {16'h7E01, 16'h8000, 16'hBC00, 16'h3C00}, {16'h7E00, 16'h0000, 16'h0000, 16'h3C00});
    direct("leaky",  2'b10, {16'h4500, 16'hFC00, 16'h8001, 16'hC000}, {16'h4500, 16'hFC00, 16'h8000, 16'hB400});
    direct("relu6",  2'b11, {16'h3800, 16'h7C00, 16'h4601, 16'h4600}, {16'h3800, 16'h4600, 16'h4600, 16'h4600});
    direct("bypass", 2'b00, {16'h3800, 16'h7C00, 16'h4601, 16'h4600}, {16'h3800, 16'h7C00, 16'h4601, 16'h4600});

    // Frame 1 latches ReLU; the switch at beat 100 must not take effect.
    rand_ready = 1'b1;
    bus.mode = 2'b01;
    send_frame(FRAME, 100, 2'b10);
    drain();
    chk("frames_after_1", 80'(fd_count), 80'(1));

    // Frame 2 picks up leaky.
    send_frame(FRAME, -1, 2'b00);
    drain();
    chk("frames_after_2", 80'(fd_count), 80'(2));

    // Frame 3: stall on beat 500 and reset.
    bus.mode = 2'b11;
    send_frame(400, -1, 2'b00);
    rand_ready  = 1'b0;
    ready_force = 1'b1;
    send_frame(101, -1, 2'b00);
    ready_force = 1'b0;
    step();
    @(negedge clk);
    chk("stall_in_ready",  80'(bus.in_ready),  80'(1'b0));
    chk("stall_out_valid", 80'(bus.out_valid), 80'(1'b1));
    chk("stall_queue",     80'(exp_q.size()),  80'(1));
    if (exp_q.size() != 0)
      chk("stall_held_beat", 80'({bus.out_chan, bus.out_last_chan, bus.out_last, bus.out_data}), 80'(exp_q[0]));
    step();
    do_reset(1);
    @(negedge clk);
    chk("mid_reset_out_valid", 80'(bus.out_valid), 80'(1'b0));
    chk("mid_reset_frame_cnt", 80'(fd_count),      80'(2));
    step();

    // Frame 4 restarts at channel 0.
    ready_force = 1'b1;
    rand_ready  = 1'b1;
    bus.mode    = 2'b10;
    send_frame(FRAME, -1, 2'b00);
    drain();
    chk("frames_after_4", 80'(fd_count), 80'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
